// File: rtl/smd_pad_pkg.sv
// Shared types and constants for the Mega Drive pad reader: FSM states,
// button/pin/phase indices and the capture-to-report decode.
package smd_pad_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SCAN   = 2'd1,
      COMMIT = 2'd2
   } state_e;

   // btn bit positions, {md,x,y,z,st,c,b,a,rg,lf,dw,up}
   localparam int BTN_UP = 0;
   localparam int BTN_DW = 1;
   localparam int BTN_LF = 2;
   localparam int BTN_RG = 3;
   localparam int BTN_A  = 4;
   localparam int BTN_B  = 5;
   localparam int BTN_C  = 6;
   localparam int BTN_ST = 7;
   localparam int BTN_Z  = 8;
   localparam int BTN_Y  = 9;
   localparam int BTN_X  = 10;
   localparam int BTN_MD = 11;

   // DB9 data pins within p
   localparam int PIN1 = 5;
   localparam int PIN2 = 4;
   localparam int PIN3 = 3;
   localparam int PIN4 = 2;
   localparam int PIN6 = 1;
   localparam int PIN9 = 0;

   localparam int PH_ID3 = 0;
   localparam int PH_DIR = 1;
   localparam int PH_ID6 = 4;
   localparam int PH_XYZ = 5;

   typedef struct packed {
      logic [11:0] btn;
      logic        present;
      logic        six;
   } pad_rpt_t;

   // Pin levels are active-low; a missing pad floats every pin high.
   function automatic pad_rpt_t smd_decode(input logic [5:0] c0, input logic [5:0] c1,
                                           input logic [5:0] c4, input logic [5:0] c5);
      pad_rpt_t r;
      r = '0;
      r.present = (c0[PIN3:PIN4] == 2'b00);
      if (r.present) begin
         r.btn[BTN_UP] = ~c1[PIN1];
         r.btn[BTN_DW] = ~c1[PIN2];
         r.btn[BTN_LF] = ~c1[PIN3];
         r.btn[BTN_RG] = ~c1[PIN4];
         r.btn[BTN_B]  = ~c1[PIN6];
         r.btn[BTN_C]  = ~c1[PIN9];
         r.btn[BTN_A]  = ~c0[PIN6];
         r.btn[BTN_ST] = ~c0[PIN9];
         r.six = (c4[PIN1:PIN4] == 4'b0000);
         if (r.six) begin
            r.btn[BTN_Z]  = ~c5[PIN1];
            r.btn[BTN_Y]  = ~c5[PIN2];
            r.btn[BTN_X]  = ~c5[PIN3];
            r.btn[BTN_MD] = ~c5[PIN4];
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/smd_pad_reader_sync.sv
// Two-flop synchronizer for the asynchronous pad pins; resets to all-ones
// so an idle bus reads as "no buttons, no pad".
module smd_pin_sync #(
   parameter int W = 6
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [W-1:0] i_d,
   output logic [W-1:0] o_q
);

   logic [W-1:0] r_s1;
   logic [W-1:0] r_s2;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_s1 <= '1;
         r_s2 <= '1;
      end else begin
         r_s1 <= i_d;
         r_s2 <= r_s1;
      end
   end

   assign o_q = r_s2;

endmodule

// File: rtl/smd_pad_reader.sv
// Host side of the SEL-multiplexed Genesis pad protocol: idles, walks the
// eight SEL phases, captures pins mid-phase and publishes one snapshot per poll.
module smd_pad_reader
   import smd_pad_pkg::*;
#(
   parameter int PHASE_CYCLES = 100,
   parameter int SAMPLE_AT    = 90,
   parameter int POLL_CYCLES  = 166666
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [5:0]  p,
   output logic        sel,
   output logic [11:0] btn,
   output logic        pad_present,
   output logic        six_button,
   output logic        valid
);

   localparam int CW = (PHASE_CYCLES > 1) ? $clog2(PHASE_CYCLES) : 1;
   localparam int PW = (POLL_CYCLES > 1) ? $clog2(POLL_CYCLES) : 1;

   localparam logic [CW-1:0] CYC_LAST  = CW'(PHASE_CYCLES - 1);
   localparam logic [CW-1:0] CYC_SMP   = CW'(SAMPLE_AT);
   localparam logic [PW-1:0] POLL_LAST = PW'(POLL_CYCLES - 1);

   localparam logic [2:0] P_ID3  = 3'(PH_ID3);
   localparam logic [2:0] P_DIR  = 3'(PH_DIR);
   localparam logic [2:0] P_ID6  = 3'(PH_ID6);
   localparam logic [2:0] P_XYZ  = 3'(PH_XYZ);
   localparam logic [2:0] P_LAST = 3'd7;

   state_e        r_state;
   state_e        w_state_nxt;
   logic [PW-1:0] r_poll;
   logic [CW-1:0] r_cyc;
   logic [2:0]    r_phase;
   logic [2:0]    w_phase_inc;
   logic          r_sel;
   logic          w_sel_nxt;
   logic          w_cap_en;
   logic          w_poll_done;
   logic          w_phase_end;
   logic          w_scan_done;
   logic [5:0]    w_ps;
   logic [5:0]    r_c0, r_c1, r_c4, r_c5;
   pad_rpt_t      w_rpt;
   logic [11:0]   r_btn;
   logic          r_present;
   logic          r_six;
   logic          r_valid;

   smd_pin_sync #(.W(6)) u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .i_d   (p),
      .o_q   (w_ps)
   );

   assign w_poll_done = (r_state == IDLE) && (r_poll == POLL_LAST);
   assign w_phase_end = (r_state == SCAN) && (r_cyc == CYC_LAST);
   assign w_scan_done = w_phase_end && (r_phase == P_LAST);
   assign w_phase_inc = r_phase + 3'd1;

   always_ff @(posedge clk) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (w_poll_done) w_state_nxt = SCAN;
         SCAN:    if (w_scan_done) w_state_nxt = COMMIT;
         COMMIT:  w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   // sel is registered, so it is computed one cycle ahead of the phase it drives
   always_comb begin
      w_sel_nxt = 1'b1;
      w_cap_en  = 1'b0;
      case (r_state)
         IDLE: w_sel_nxt = ~w_poll_done;
         SCAN: begin
            w_sel_nxt = r_sel;
            w_cap_en  = (r_cyc == CYC_SMP);
            if (w_phase_end && !w_scan_done) w_sel_nxt = w_phase_inc[0];
         end
         default: w_sel_nxt = 1'b1;
      endcase
   end

   assign w_rpt = smd_decode(r_c0, r_c1, r_c4, r_c5);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_poll    <= '0;
         r_cyc     <= '0;
         r_phase   <= '0;
         r_sel     <= 1'b1;
         r_c0      <= '1;
         r_c1      <= '1;
         r_c4      <= '1;
         r_c5      <= '1;
         r_btn     <= '0;
         r_present <= 1'b0;
         r_six     <= 1'b0;
         r_valid   <= 1'b0;
      end else begin
         r_sel   <= w_sel_nxt;
         r_valid <= w_scan_done;

         if (r_state == IDLE && !w_poll_done) r_poll <= r_poll + PW'(1);
         else                                 r_poll <= '0;

         if (r_state == SCAN && !w_phase_end) r_cyc <= r_cyc + CW'(1);
         else                                 r_cyc <= '0;

         if (w_phase_end)            r_phase <= w_scan_done ? 3'd0 : w_phase_inc;
         else if (r_state != SCAN)   r_phase <= '0;

         // Phases 2, 3, 6, 7 only clock the pad's internal counter
         if (w_cap_en) begin
            case (r_phase)
               P_ID3:   r_c0 <= w_ps;
               P_DIR:   r_c1 <= w_ps;
               P_ID6:   r_c4 <= w_ps;
               P_XYZ:   r_c5 <= w_ps;
               default: ;
            endcase
         end

         if (w_scan_done) begin
            r_btn     <= w_rpt.btn;
            r_present <= w_rpt.present;
            r_six     <= w_rpt.six;
         end
      end
   end

   assign sel         = r_sel;
   assign btn         = r_btn;
   assign pad_present = r_present;
   assign six_button  = r_six;
   assign valid       = r_valid;

endmodule
